// File: rtl/fp4_fft_pkg.sv
// Shared types and helpers for the FP4 radix-2 FFT engine.
// FP4 (E2M1) codec, Q1.6 twiddle ROM, FSM states, bit reversal.
package fp4_fft_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} fft_state_e;

  // Twiddle ROM resolution; MAX_N must divide this
  localparam int TW_N = 32;

  function automatic logic signed [15:0] fp4_dec(input logic [3:0] f);
    logic signed [15:0] m;
    unique case (f[2:0])
      3'd0: m = 16'sd0;
      3'd1: m = 16'sd1;
      3'd2: m = 16'sd2;
      3'd3: m = 16'sd3;
      3'd4: m = 16'sd4;
      3'd5: m = 16'sd6;
      3'd6: m = 16'sd8;
      3'd7: m = 16'sd12;
    endcase
    return f[3] ? -m : m;
  endfunction

  // v in 1/128 units; nearest, ties to even mantissa, saturate at 6.0
  function automatic logic [3:0] fp4_enc(input logic signed [15:0] v);
    logic [15:0] m;
    logic [2:0] c;
    m = v[15] ? 16'(-v) : 16'(v);
    if (m <= 16'd32) c = 3'd0;
    else if (m < 16'd96) c = 3'd1;
    else if (m <= 16'd160) c = 3'd2;
    else if (m < 16'd224) c = 3'd3;
    else if (m <= 16'd320) c = 3'd4;
    else if (m < 16'd448) c = 3'd5;
    else if (m <= 16'd640) c = 3'd6;
    else c = 3'd7;
    return {v[15] && (c != 3'd0), c};
  endfunction

  function automatic logic signed [7:0] tw_re(input int m);
    case (m)
      0: return 8'sd64;
      1: return 8'sd63;
      2: return 8'sd59;
      3: return 8'sd53;
      4: return 8'sd45;
      5: return 8'sd36;
      6: return 8'sd24;
      7: return 8'sd12;
      9: return -8'sd12;
      10: return -8'sd24;
      11: return -8'sd36;
      12: return -8'sd45;
      13: return -8'sd53;
      14: return -8'sd59;
      15: return -8'sd63;
      default: return 8'sd0;
    endcase
  endfunction

  function automatic logic signed [7:0] tw_im(input int m);
    case (m)
      1: return -8'sd12;
      2: return -8'sd24;
      3: return -8'sd36;
      4: return -8'sd45;
      5: return -8'sd53;
      6: return -8'sd59;
      7: return -8'sd63;
      8: return -8'sd64;
      9: return -8'sd63;
      10: return -8'sd59;
      11: return -8'sd53;
      12: return -8'sd45;
      13: return -8'sd36;
      14: return -8'sd24;
      15: return -8'sd12;
      default: return 8'sd0;
    endcase
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v,
                                         input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[w-1-i] = v[i];
    return r;
  endfunction

endpackage

// File: rtl/fp4_butterfly.sv
// Combinational radix-2 butterfly on packed FP4 complex samples.
// A' = A + W*B, B' = A - W*B with exact products before re-encoding.
module fp4_butterfly
  import fp4_fft_pkg::*;
(
  input  logic [7:0]        a,
  input  logic [7:0]        b,
  input  logic signed [7:0] w_re,
  input  logic signed [7:0] w_im,
  output logic [7:0]        a_out,
  output logic [7:0]        b_out
);

  logic signed [15:0] ar, ai, br, bi, wr, wi, pr, pi;

  always_comb begin
    wr = 16'(w_re);
    wi = 16'(w_im);
    // A scaled to the 1/128 grid of the twiddle products
    ar = fp4_dec(a[7:4]) * 16'sd64;
    ai = fp4_dec(a[3:0]) * 16'sd64;
    br = fp4_dec(b[7:4]);
    bi = fp4_dec(b[3:0]);
    pr = br * wr - bi * wi;
    pi = br * wi + bi * wr;
    a_out = {fp4_enc(ar + pr), fp4_enc(ai + pi)};
    b_out = {fp4_enc(ar - pr), fp4_enc(ai - pi)};
  end

endmodule

// File: rtl/fp4_fft.sv
// In-place radix-2 DIT FFT over ping-pong FP4 banks.
// Two cycles per butterfly: operand read, then result write.
module fp4_fft
  import fp4_fft_pkg::*;
#(
  parameter int MAX_N      = 32,
  parameter int ADDR_WIDTH = $clog2(MAX_N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  input  logic                  ext_wr_en,
  input  logic [ADDR_WIDTH-1:0] ext_wr_addr,
  input  logic [7:0]            ext_wr_data,
  input  logic [ADDR_WIDTH-1:0] ext_rd_addr,
  output logic [7:0]            ext_rd_data
);

  localparam int AW = ADDR_WIDTH;
  localparam int TW_SCALE = TW_N / MAX_N;
  localparam logic [AW-1:0] LAST_STAGE = AW'(AW - 1);
  localparam logic [AW-1:0] HALF_M1 = AW'(MAX_N / 2 - 1);

  fft_state_e state_q, state_d;
  logic bank_sel_q, bank_sel_d;
  logic [AW-1:0] bfly_q, bfly_d;
  logic [AW-1:0] grp_q, grp_d;
  logic [AW-1:0] stage_q, stage_d;
  logic [7:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [7:0] bank_q [2][MAX_N];
  logic [7:0] bank_d [2][MAX_N];

  logic [AW-1:0] stride, idx_a, idx_b, grp_last, tw_k, wr_idx;
  logic signed [7:0] w_re, w_im;
  logic [7:0] res_a, res_b;

  always_comb begin
    stride = AW'(1) << stage_q;
    idx_a = (grp_q << (stage_q + AW'(1))) | bfly_q;
    idx_b = idx_a | stride;
    grp_last = HALF_M1 >> stage_q;
    tw_k = bfly_q << (LAST_STAGE - stage_q);
    w_re = tw_re(int'(tw_k) * TW_SCALE);
    w_im = tw_im(int'(tw_k) * TW_SCALE);
    wr_idx = AW'(bitrev(32'(ext_wr_addr), AW));
  end

  fp4_butterfly u_bfly (
    .a     (op_a_q),
    .b     (op_b_q),
    .w_re  (w_re),
    .w_im  (w_im),
    .a_out (res_a),
    .b_out (res_b)
  );

  assign done = (state_q == DONE);
  assign ext_rd_data = bank_q[bank_sel_q][ext_rd_addr];

  always_comb begin
    state_d = state_q;
    bank_sel_d = bank_sel_q;
    bfly_d = bfly_q;
    grp_d = grp_q;
    stage_d = stage_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    bank_d = bank_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (ext_wr_en) bank_d[0][wr_idx] = ext_wr_data;
        if (start) begin
          state_d = RD;
          bank_sel_d = 1'b0;
          bfly_d = '0;
          grp_d = '0;
          stage_d = '0;
        end
      end
      RD: begin
        op_a_d = bank_q[bank_sel_q][idx_a];
        op_b_d = bank_q[bank_sel_q][idx_b];
        state_d = WR;
      end
      WR: begin
        bank_d[~bank_sel_q][idx_a] = res_a;
        bank_d[~bank_sel_q][idx_b] = res_b;
        state_d = RD;
        if (bfly_q == stride - AW'(1)) begin
          bfly_d = '0;
          if (grp_q == grp_last) begin
            grp_d = '0;
            bank_sel_d = ~bank_sel_q;
            if (stage_q == LAST_STAGE) begin
              stage_d = '0;
              state_d = DONE;
            end else begin
              stage_d = stage_q + AW'(1);
            end
          end else begin
            grp_d = grp_q + AW'(1);
          end
        end else begin
          bfly_d = bfly_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bank_sel_q <= 1'b0;
      bfly_q <= '0;
      grp_q <= '0;
      stage_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < MAX_N; i++)
          bank_q[b][i] <= '0;
    end else begin
      state_q <= state_d;
      bank_sel_q <= bank_sel_d;
      bfly_q <= bfly_d;
      grp_q <= grp_d;
      stage_q <= stage_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      bank_q <= bank_d;
    end
  end

endmodule

// File: tb/tb_fp4_fft.sv
// Directed bench for fp4_fft: impulse, zero, DC, shifted impulses,
// busy protection, mid-run reset and restart.
module tb_fp4_fft;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst, start, done, ext_wr_en;
  logic [4:0] ext_wr_addr, ext_rd_addr;
  logic [7:0] ext_wr_data, ext_rd_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] vec [N];
  logic [7:0] exp_v [N];

  always #5 clk = ~clk;

  fp4_fft #(.MAX_N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .done        (done),
    .ext_wr_en   (ext_wr_en),
    .ext_wr_addr (ext_wr_addr),
    .ext_wr_data (ext_wr_data),
    .ext_rd_addr (ext_rd_addr),
    .ext_rd_data (ext_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v, input logic [7:0] e);
    for (int i = 0; i < N; i++) begin
      vec[i] = v;
      exp_v[i] = e;
    end
  endtask

  task automatic load();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      ext_wr_en = 1'b1;
      ext_wr_addr = 5'(i);
      ext_wr_data = vec[i];
    end
    @(negedge clk);
    ext_wr_en = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < N; i++) begin
      ext_rd_addr = 5'(i);
      #1;
      check($sformatf("%s[%0d]", tag, i), ext_rd_data, exp_v[i]);
    end
  endtask

  task automatic run(input string tag, input bit poke);
    int cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_done_fall"}, done, 0);
    cnt = 0;
    while (!done && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      if (poke && cnt == 20) begin
        start = 1'b1;
        ext_wr_en = 1'b1;
        ext_wr_addr = 5'd0;
        ext_wr_data = 8'h70;
      end else begin
        start = 1'b0;
        ext_wr_en = 1'b0;
      end
    end
    check({tag, "_latency"}, cnt, 160);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    ext_wr_en = 1'b0;
    ext_wr_addr = '0;
    ext_wr_data = '0;
    ext_rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_done", done, 0);
    fill(8'h00, 8'h00);
    read_all("rst_bin");

    fill(8'h00, 8'h20);
    vec[0] = 8'h20;
    load();
    run("imp", 1'b1);
    read_all("imp");

    fill(8'h00, 8'h00);
    load();
    run("zero", 1'b0);
    read_all("zero");

    fill(8'h20, 8'h00);
    exp_v[0] = 8'h70;
    load();
    run("dc", 1'b0);
    read_all("dc");

    fill(8'h00, 8'h00);
    vec[16] = 8'h20;
    for (int i = 0; i < N; i++) exp_v[i] = i[0] ? 8'hA0 : 8'h20;
    load();
    run("alt", 1'b0);
    read_all("alt");

    fill(8'h00, 8'h00);
    vec[8] = 8'h20;
    for (int i = 0; i < N; i += 4) begin
      exp_v[i] = 8'h20;
      exp_v[i+1] = 8'h0A;
      exp_v[i+2] = 8'hA0;
      exp_v[i+3] = 8'h02;
    end
    load();
    run("quad", 1'b0);
    read_all("quad");

    fill(8'h00, 8'h20);
    vec[0] = 8'h20;
    load();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_done", done, 0);
    fill(8'h00, 8'h00);
    read_all("midrst");
    fill(8'h00, 8'h20);
    vec[0] = 8'h20;
    load();
    run("reimp", 1'b0);
    read_all("reimp");

    check("pre_restart_done", done, 1);
    fill(8'h00, 8'h00);
    load();
    run("restart", 1'b0);
    read_all("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
